// File: rtl/mem_port_arbiter_if.sv
// CPU, loader and memory-macro signals of the arbiter.
// slave is the arbiter's view; master is the requesters' and memory's view.
interface mem_port_arbiter_if #(
  parameter int N      = 32,
  parameter int ADDR_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [N-1:0]      cpu_wdata;
  logic [N-1:0]      cpu_rdata;
  logic              cpu_ready;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [N-1:0]      ldr_wdata;
  logic [N-1:0]      ldr_rdata;
  logic              ldr_ready;
  logic              ldr_done;

  logic [ADDR_W-1:0] mem_addr;
  logic [N-1:0]      mem_wdata;
  logic              mem_we;
  logic [N-1:0]      mem_rdata;
  logic [1:0]        owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_done,
    output ldr_rdata, ldr_ready,
    output mem_addr, mem_wdata, mem_we, owner,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_done,
    input  ldr_rdata, ldr_ready,
    input  mem_addr, mem_wdata, mem_we, owner,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin CPU/loader arbiter for a single-port memory; MEM_ARB_BOOT_HOLD_EN holds CPU off until ldr_done.
// Ready 2 cycles after grant for writes, 2+LATENCY for reads; requesters hold req until their ready pulse.
module mem_port_arbiter #(
  parameter int N       = 32,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_LDR  = 2'b10;
  localparam logic [3:0] LAT_CNT  = 4'(LATENCY);

  state_t            state, state_nxt;
  logic [1:0]        owner_q;
  logic              last_ldr;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [N-1:0]      wdata_q;
  logic [3:0]        cnt_q;
  logic [N-1:0]      cpu_rdata_q;
  logic [N-1:0]      ldr_rdata_q;

  logic grant_cpu, grant_ldr, capture;
  logic mem_we_c, cpu_ready_c, ldr_ready_c;
  logic cpu_ok;

`ifdef MEM_ARB_BOOT_HOLD_EN
  logic boot_released;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      boot_released <= 1'b0;
    else if (bus.ldr_done)
      boot_released <= 1'b1;
  end

  assign cpu_ok = bus.cpu_req & boot_released;
`else
  logic unused_ldr_done;
  assign unused_ldr_done = bus.ldr_done;
  assign cpu_ok          = bus.cpu_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    grant_cpu   = 1'b0;
    grant_ldr   = 1'b0;
    capture     = 1'b0;
    mem_we_c    = 1'b0;
    cpu_ready_c = 1'b0;
    ldr_ready_c = 1'b0;
    case (state)
      S_IDLE: begin
        // On a tie, the port that did not win last time goes first.
        if (cpu_ok && bus.ldr_req) begin
          grant_cpu = last_ldr;
          grant_ldr = !last_ldr;
        end else begin
          grant_cpu = cpu_ok;
          grant_ldr = bus.ldr_req;
        end
        if (grant_cpu || grant_ldr)
          state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        mem_we_c  = we_q;
        state_nxt = we_q ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          capture   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        cpu_ready_c = (owner_q == OWN_CPU);
        ldr_ready_c = (owner_q == OWN_LDR);
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q     <= OWN_NONE;
      last_ldr    <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= 4'd0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      if (grant_cpu) begin
        we_q     <= bus.cpu_we;
        addr_q   <= bus.cpu_addr;
        wdata_q  <= bus.cpu_wdata;
        owner_q  <= OWN_CPU;
        last_ldr <= 1'b0;
      end else if (grant_ldr) begin
        we_q     <= bus.ldr_we;
        addr_q   <= bus.ldr_addr;
        wdata_q  <= bus.ldr_wdata;
        owner_q  <= OWN_LDR;
        last_ldr <= 1'b1;
      end else if (state == S_DONE) begin
        owner_q <= OWN_NONE;
      end

      if (state == S_ACCESS && !we_q)
        cnt_q <= LAT_CNT;
      else if (state == S_WAIT)
        cnt_q <= cnt_q - 4'd1;

      // Read data lands only in the register of the port that issued the read.
      if (capture && owner_q == OWN_CPU)
        cpu_rdata_q <= bus.mem_rdata;
      if (capture && owner_q == OWN_LDR)
        ldr_rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = mem_we_c;
  assign bus.owner     = owner_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.ldr_rdata = ldr_rdata_q;
  assign bus.cpu_ready = cpu_ready_c;
  assign bus.ldr_ready = ldr_ready_c;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port synchronous unified instruction/data memory of the multicycle CPU between two requesters:
  - the CPU memory interface, driven by the control FSM (IorD path);
  - a program loader port used for boot and debug writes and reads.
- Sequences each access: address issue, read-latency wait, data capture, and a one-cycle ready handshake.
- Sits between the CPU datapath and the memory macro.

Parameters:
- N, 32, data width.
- ADDR_W, 32, address width (passed through unchanged).
- LATENCY, 1, memory read latency in cycles; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- cpu_req  in  1  CPU access request; held high until cpu_ready is seen.
- cpu_we  in  1  1 = write, 0 = read; sampled at grant.
- cpu_addr  in  ADDR_W  CPU address; sampled at grant.
- cpu_wdata  in  N  CPU write data; sampled at grant.
- cpu_rdata  out  N  CPU read data; valid when cpu_ready=1, held afterwards.
- cpu_ready  out  1  one-cycle completion pulse.
- ldr_req, ldr_we, ldr_addr, ldr_wdata  in  1/1/ADDR_W/N  loader request signals, same rules as the CPU port.
- ldr_rdata  out  N  loader read data.
- ldr_ready  out  1  loader completion pulse.
- ldr_done  in  1  loader finished boot image (used only by the optional feature).
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  N  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  N  memory read data, valid LATENCY cycles after address issue.
- owner  out  2  00 none, 01 CPU, 10 loader.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All outputs 0, including cpu_rdata and ldr_rdata.
  - last_grant=loader.
  - Latency counter 0.
- States: IDLE, ACCESS, WAIT, DONE. Encoding is free; the FSM is registered with a separate next-state block.
- IDLE:
  - No requests: stay IDLE, owner=00.
  - One requester: grant it.
  - Both requesting: grant the one not equal to last_grant (round-robin). After reset the CPU wins the first tie.
  - On grant, at the clock edge: latch we, addr and wdata into mem_addr/mem_wdata; set owner; update last_grant; go to ACCESS.
- ACCESS (1 cycle):
  - mem_we=latched we.
  - Write: next state DONE.
  - Read: load counter with LATENCY, next state WAIT.
- WAIT:
  - mem_we=0; mem_addr and mem_wdata held.
  - Counter decrements each cycle.
  - In the cycle the counter reaches 1: capture mem_rdata into the owner's rdata register at the edge, then go to DONE.
- DONE (1 cycle):
  - The owner's ready=1; the other port's ready stays 0.
  - Requests are ignored this cycle.
  - Next state IDLE; owner becomes 00 on entry to IDLE.
- Latency, with a request sampled at edge 0:
  - Write: mem_we high in cycle 1, ready in cycle 2.
  - Read: ready in cycle 2+LATENCY.
  - Minimum request-to-request spacing is 3 cycles for a write and 3+LATENCY for a read, because of the IDLE re-arbitration cycle.
- mem_we is high for exactly one cycle per write and never during a read.
- rdata of a port changes only on completion of that port's own read. It is not altered by writes or by the other port.
- A request dropped mid-transaction does not abort it: the write is still performed and ready still pulses.
- Attribute changes (we/addr/wdata) after grant are ignored.
- Reset asserted mid-transaction: return to IDLE immediately. mem_we falls asynchronously. No ready pulse is produced for the dropped access.
- A requester holding req high through DONE is re-arbitrated in the following IDLE cycle.

Optional Feature:
- Macro: MEM_ARB_BOOT_HOLD_EN.
- Defined:
  - After reset, CPU requests are not granted until ldr_done has been sampled high.
  - A sticky boot_released flag records this and is cleared only by reset.
  - Loader requests are served normally throughout.
- Undefined: ldr_done is ignored; the CPU is eligible from the first cycle after reset.
- The ldr_done port exists in both builds.

Test Plan:
- Single CPU write: cpu_req=1, cpu_we=1, addr=0x10, wdata=0xDEADBEEF.
  - Expect mem_we=1 with mem_addr=0x10 in cycle 1.
  - Expect cpu_ready=1 in cycle 2; owner=01 in cycles 1-2.
- CPU read with LATENCY=3: memory returns 0x12345678 for addr 0x20.
  - Expect cpu_ready in cycle 5 with cpu_rdata=0x12345678, held afterwards.
  - mem_we stays 0 throughout.
- Simultaneous requests, both held high across three transactions:
  - Grants are CPU, loader, CPU.
  - Each ready pulse goes only to its owner; ldr_rdata is unchanged by the CPU reads.
- Reset pulse (rst=0) in WAIT of a loader read: outputs immediately 0, no ldr_ready, state IDLE.
  - After release, a tie is won by the CPU.
- Request dropped after grant on a write: write still occurs and the ready pulse is still produced.
- MEM_ARB_BOOT_HOLD_EN defined:
  - cpu_req held for 20 cycles with ldr_done=0: no grant, owner=00.
  - Pulse ldr_done=1: the CPU is granted in the next IDLE cycle.
